// File: rtl/tank_pkg.sv
// Shared definitions for the tank movement front end: keycodes, direction
// bit positions inside the 4-bit direction mask, and the report FSM states.
package tank_pkg;

  localparam logic [7:0] KC_W        = 8'h1A;
  localparam logic [7:0] KC_S        = 8'h16;
  localparam logic [7:0] KC_A        = 8'h04;
  localparam logic [7:0] KC_D        = 8'h07;
  localparam logic [7:0] KC_UP       = 8'h52;
  localparam logic [7:0] KC_DOWN     = 8'h51;
  localparam logic [7:0] KC_LEFT     = 8'h50;
  localparam logic [7:0] KC_RIGHT    = 8'h4F;
  localparam logic [7:0] KC_SPACE    = 8'h2C;
  localparam logic [7:0] KC_ENTER    = 8'h28;
  localparam logic [7:0] KC_ROLLOVER = 8'h01;
  localparam logic [7:0] KC_NONE     = 8'h00;

  // Mask bit order is {up, down, left, right}; the highest bit has priority.
  localparam int DIR_UP    = 3;
  localparam int DIR_DOWN  = 2;
  localparam int DIR_LEFT  = 1;
  localparam int DIR_RIGHT = 0;

  typedef enum logic [1:0] {IDLE, COLLECT, COMMIT} state_t;

  // Maps a keycode to the one-hot direction bit of the chosen player (0 if none).
  function automatic logic [3:0] kc_to_mask(input logic [7:0] kc, input logic p2);
    logic [3:0] m;
    m = '0;
    m[DIR_UP]    = (kc == (p2 ? KC_UP    : KC_W));
    m[DIR_DOWN]  = (kc == (p2 ? KC_DOWN  : KC_S));
    m[DIR_LEFT]  = (kc == (p2 ? KC_LEFT  : KC_A));
    m[DIR_RIGHT] = (kc == (p2 ? KC_RIGHT : KC_D));
    return m;
  endfunction

endpackage

// File: rtl/dir_select.sv
// Priority picker: turns a direction mask into the keycode of its
// highest-priority direction (up > down > left > right) for one player.
module dir_select
  import tank_pkg::*;
(
  input  logic [3:0] mask_i,
  input  logic       p2_i,
  output logic [7:0] keycode_o
);

  // Fixed-priority encode; an empty mask yields KC_NONE.
  always_comb begin
    keycode_o = KC_NONE;
    if (mask_i[DIR_UP])         keycode_o = p2_i ? KC_UP    : KC_W;
    else if (mask_i[DIR_DOWN])  keycode_o = p2_i ? KC_DOWN  : KC_S;
    else if (mask_i[DIR_LEFT])  keycode_o = p2_i ? KC_LEFT  : KC_A;
    else if (mask_i[DIR_RIGHT]) keycode_o = p2_i ? KC_RIGHT : KC_D;
  end

endmodule

// File: rtl/key_router.sv
// Keyboard report router: assembles each serial boot-keyboard report into
// per-player direction masks, arbitrates newest-press-wins on commit, and
// presents one frame-aligned movement keycode per player.
// Optional feature macro KEY_ROUTER_FIRE_EN adds one-frame fire pulses
// (space for player 1, Enter for player 2).
module key_router
  import tank_pkg::*;
#(
  parameter int MAX_SLOTS = 6
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       kc_valid,
  input  logic [7:0] kc_data,
  input  logic       kc_last,
  input  logic       frame_start,
  output logic [7:0] p1_keycode,
  output logic [7:0] p2_keycode
`ifdef KEY_ROUTER_FIRE_EN
  ,
  output logic       p1_fire,
  output logic       p2_fire
`endif
);

  localparam int CW = $clog2(MAX_SLOTS + 1);

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic              roll_q;
  logic [1:0][3:0]   cur_q, prev_q, beat_m;
  logic [1:0][7:0]   held_q, held_d;
  logic              accept, commit_ok;

  // Beats past the slot limit are dropped, but their kc_last still closes the report.
  assign accept    = kc_valid && (state_q != COMMIT) && (cnt_q < CW'(MAX_SLOTS));
  assign commit_ok = (state_q == COMMIT) && !roll_q;

  for (genvar p = 0; p < 2; p++) begin : g_player
    localparam logic P2 = (p == 1);
    logic [3:0] new_m, held_m;
    logic [7:0] kc_new, kc_cur;

    assign beat_m[p] = kc_to_mask(kc_data, P2);
    assign new_m     = cur_q[p] & ~prev_q[p];
    assign held_m    = kc_to_mask(held_q[p], P2);

    dir_select u_sel_new (.mask_i(new_m),    .p2_i(P2), .keycode_o(kc_new));
    dir_select u_sel_cur (.mask_i(cur_q[p]), .p2_i(P2), .keycode_o(kc_cur));

    // A fresh press wins; otherwise keep a still-held key, else fall back to
    // the best key still down (KC_NONE when the mask is empty).
    assign held_d[p] = !commit_ok                ? held_q[p] :
                       (|new_m)                  ? kc_new    :
                       (|(held_m & cur_q[p]))    ? held_q[p] : kc_cur;
  end

  // Report FSM: accumulate beats, then commit or discard (rollover) for one cycle.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      roll_q  <= 1'b0;
      cur_q   <= '0;
      prev_q  <= '0;
      held_q  <= '0;
    end else begin
      held_q <= held_d;
      case (state_q)
        IDLE, COLLECT: begin
          if (accept) begin
            cur_q <= cur_q | beat_m;
            cnt_q <= cnt_q + 1'b1;
            if (kc_data == KC_ROLLOVER) roll_q <= 1'b1;
          end
          if (kc_valid && kc_last) state_q <= COMMIT;
          else if (kc_valid)       state_q <= COLLECT;
        end
        COMMIT: begin
          if (!roll_q) prev_q <= cur_q;
          cur_q   <= '0;
          cnt_q   <= '0;
          roll_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Frame-aligned outputs; held_d gives the same-cycle commit bypass.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      p1_keycode <= KC_NONE;
      p2_keycode <= KC_NONE;
    end else if (frame_start) begin
      p1_keycode <= held_d[0];
      p2_keycode <= held_d[1];
    end
  end

`ifdef KEY_ROUTER_FIRE_EN
  logic [1:0] fire_cur_q, fire_prev_q, fire_pend_q, fire_q, fire_beat, fire_new;

  assign fire_beat = {kc_data == KC_ENTER, kc_data == KC_SPACE};
  assign fire_new  = commit_ok ? (fire_cur_q & ~fire_prev_q) : 2'b00;
  assign p1_fire   = fire_q[0];
  assign p2_fire   = fire_q[1];

  // Fire edges are collected until the next frame, then shown for exactly one frame.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fire_cur_q  <= '0;
      fire_prev_q <= '0;
      fire_pend_q <= '0;
      fire_q      <= '0;
    end else begin
      if (accept) begin
        fire_cur_q <= fire_cur_q | fire_beat;
      end else if (state_q == COMMIT) begin
        fire_cur_q <= '0;
        if (!roll_q) fire_prev_q <= fire_cur_q;
      end
      if (frame_start) begin
        fire_q      <= fire_pend_q | fire_new;
        fire_pend_q <= '0;
      end else begin
        fire_pend_q <= fire_pend_q | fire_new;
      end
    end
  end
`endif

endmodule

// File: tb/tb_key_router.sv
// Directed bench for key_router (default build, fire outputs absent).
module tb_key_router;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       kc_valid = 1'b0;
  logic [7:0] kc_data = 8'h00;
  logic       kc_last = 1'b0;
  logic       frame_start = 1'b0;
  logic [7:0] p1_keycode, p2_keycode;

  int errors = 0;
  int checks = 0;
  logic [7:0] rep[$];

  key_router #(.MAX_SLOTS(6)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .kc_valid(kc_valid), .kc_data(kc_data),
    .kc_last(kc_last), .frame_start(frame_start),
    .p1_keycode(p1_keycode), .p2_keycode(p2_keycode)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive the beats in rep, optionally with frame_start during the COMMIT cycle.
  task automatic send_report(input bit frame_in_commit);
    for (int i = 0; i < rep.size(); i++) begin
      @(negedge Clk);
      kc_valid = 1'b1;
      kc_data  = rep[i];
      kc_last  = (i == rep.size() - 1);
    end
    @(negedge Clk);
    kc_valid = 1'b0;
    kc_data  = 8'h00;
    kc_last  = 1'b0;
    frame_start = frame_in_commit;
    @(negedge Clk);
    frame_start = 1'b0;
    @(negedge Clk);
  endtask

  task automatic frame();
    @(negedge Clk);
    frame_start = 1'b1;
    @(negedge Clk);
    frame_start = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge Clk);
    check("reset_p1", p1_keycode, 8'h00);
    check("reset_p2", p2_keycode, 8'h00);
    Reset_n = 1'b1;
    @(negedge Clk);

    rep = {8'h1A};               send_report(0); frame();
    check("w_p1", p1_keycode, 8'h1A);
    check("w_p2", p2_keycode, 8'h00);

    rep = {8'h1A, 8'h07};        send_report(0);
    check("stable_no_frame", p1_keycode, 8'h1A);
    frame();
    check("newest_d", p1_keycode, 8'h07);

    rep = {8'h07};               send_report(0); frame();
    check("keep_d", p1_keycode, 8'h07);

    rep = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_report(0); frame();
    check("all_released", p1_keycode, 8'h00);

    rep = {8'h04, 8'h50, 8'h2C}; send_report(0); frame();
    check("mix_p1", p1_keycode, 8'h04);
    check("mix_p2", p2_keycode, 8'h50);

    rep = {8'h16};               send_report(0); frame();
    check("s_p1", p1_keycode, 8'h16);
    check("s_p2_release", p2_keycode, 8'h00);

    rep = {8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
    send_report(0); frame();
    check("rollover_keep", p1_keycode, 8'h16);

    rep = {8'h00};               send_report(0); frame();
    check("after_rollover", p1_keycode, 8'h00);

    rep = {8'h50};               send_report(0); frame();
    check("left_p2", p2_keycode, 8'h50);

    rep = {8'h50, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h52, 8'h52};
    send_report(0); frame();
    check("overflow_ignored_p2", p2_keycode, 8'h50);
    check("overflow_commit_p1", p1_keycode, 8'h04);

    rep = {8'h07, 8'h04, 8'h16}; send_report(0); frame();
    check("prio_p1_down", p1_keycode, 8'h16);

    // Reset in the middle of a report.
    @(negedge Clk); kc_valid = 1'b1; kc_data = 8'h1A; kc_last = 1'b0;
    @(negedge Clk); kc_data = 8'h07;
    @(negedge Clk); kc_valid = 1'b0; kc_data = 8'h00;
    #2 Reset_n = 1'b0;
    @(negedge Clk);
    check("midreset_p1", p1_keycode, 8'h00);
    check("midreset_p2", p2_keycode, 8'h00);
    Reset_n = 1'b1;
    @(negedge Clk);
    frame();
    check("midreset_discard", p1_keycode, 8'h00);
    rep = {8'h16};               send_report(0); frame();
    check("clean_after_reset", p1_keycode, 8'h16);

    // frame_start coincides with COMMIT: outputs take the new value directly.
    rep = {8'h51};               send_report(1);
    check("bypass_p2", p2_keycode, 8'h51);
    check("bypass_p1", p1_keycode, 8'h00);

    rep = {8'h4F, 8'h52, 8'h51}; send_report(0); frame();
    check("prio_p2_up", p2_keycode, 8'h52);

    rep = {8'h4F, 8'h52};        send_report(0); frame();
    check("keep_up", p2_keycode, 8'h52);

    rep = {8'h4F};               send_report(0); frame();
    check("fallback_right", p2_keycode, 8'h4F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_router.md
# key_router

Upstream stage of the tank movement logic. Consumes the serial USB boot-keyboard report (up to six keycode slots per report) and produces one stable movement keycode per player. Player 1 uses WASD, player 2 the arrow keys. Outputs are frame-aligned so each tank sees exactly one key per frame, with newest-press-wins arbitration.

## Interface

**Parameters**
- `MAX_SLOTS`, default 6: keycode beats accepted per report; extra beats are ignored.

**Ports**
- `Clk`  input  1  system clock.
- `Reset_n`  input  1  asynchronous, active-low reset.
- `kc_valid`  input  1  keycode beat present on `kc_data` this cycle.
- `kc_data`  input  8  keycode slot value; `0x00` means an empty slot.
- `kc_last`  input  1  qualifies the final beat of a report; only meaningful with `kc_valid`.
- `frame_start`  input  1  one-cycle pulse at the start of each frame.
- `p1_keycode`  output  8  player-1 key: `0x04`/`0x07`/`0x16`/`0x1A`, or `0x00`.
- `p2_keycode`  output  8  player-2 key: `0x4F`/`0x50`/`0x51`/`0x52`, or `0x00`.

## Operation

**Per-player state**
- 4-bit direction mask, bit order {up, down, left, right}:
  - P1: W `0x1A`, S `0x16`, A `0x04`, D `0x07`.
  - P2: `0x52`, `0x51`, `0x50`, `0x4F`.
- Registers per player: `cur_mask` (being assembled), `prev_mask` (last committed report), `held` (committed keycode).

**FSM**
- IDLE: on `kc_valid` → COLLECT. The first beat is already accumulated in this cycle.
- COLLECT:
  - Each `kc_valid` beat ORs the matching bit into `cur_mask`; non-matching codes are ignored.
  - The beat counter saturates at `MAX_SLOTS`; beats beyond it are ignored, except that their `kc_last` is still honoured.
  - `kc_valid & kc_last` → COMMIT.
- COMMIT (one cycle), per player:
  - Rollover: if any beat in the report was `0x01`, the report is discarded. `held` and `prev_mask` are unchanged.
  - Otherwise, `new = cur_mask & ~prev_mask`:
    - if `new ≠ 0`: `held` = highest-priority bit of `new`;
    - else if `held`'s bit is in `cur_mask`: keep `held`;
    - else if `cur_mask ≠ 0`: `held` = highest-priority bit of `cur_mask`;
    - else: `held` = `0x00`.
  - Priority order: up > down > left > right.
  - `prev_mask` ← `cur_mask`; `cur_mask` ← 0; beat counter ← 0. Go to IDLE.
- A single-beat report (`kc_valid & kc_last` in IDLE) goes IDLE → COMMIT directly.

**Output stage**
- On `frame_start`, `pN_keycode` ← `held`.
- Outputs never change between `frame_start` pulses.

## Timing

- Reset state:
  - outputs `0x00`;
  - all masks 0;
  - `held` = `0x00`;
  - FSM in IDLE;
  - beat counter 0.
- COMMIT occurs in the cycle after the `kc_last` beat. `held` is visible in the cycle after COMMIT.
- `frame_start` in the same cycle as COMMIT: outputs load the newly computed `held` (bypass).
- Output latency is at most one frame after commit, with 1-cycle register delay after `frame_start`.
- `kc_valid` during COMMIT is dropped. Upstream guarantees at least one idle cycle between reports.
- Reset asserted mid-report: the partial report is discarded and everything returns to the reset state.
- A report with all slots `0x00` is a normal all-released report: `held` → `0x00`.

## Configuration

- `KEY_ROUTER_FIRE_EN` defined:
  - Adds outputs `p1_fire` (space, `0x2C`) and `p2_fire` (Enter, `0x28`), 1 bit each.
  - Each asserts for exactly one frame (set on `frame_start`, cleared on the next `frame_start`) when its key is newly pressed in a committed report.
  - Repeated presses within one frame merge into a single pulse.
  - Reset value 0.
- Undefined: the fire ports are absent and the fire keycodes are ignored like any other non-direction code.

## Structure

- Package `tank_pkg`:
  - keycode constants (WASD, arrows, space, Enter, `KC_ROLLOVER = 8'h01`, `KC_NONE = 8'h00`);
  - direction-bit indices;
  - FSM state enum `{IDLE, COLLECT, COMMIT}`.
- One sub-module, `dir_select`: combinational, mapping a 4-bit mask plus player select to the highest-priority keycode. Instantiated twice per player: once for `new`, once for `cur`.

## Test plan

- Report [`0x1A`] last, then `frame_start` → `p1_keycode = 0x1A`, `p2_keycode = 0x00`.
- Report [`0x1A`], then report [`0x1A`, `0x07`] → after the next frame, `p1_keycode = 0x07`; then report [`0x07`] → stays `0x07`; then report [`0x00`×6] → `0x00`.
- Report [`0x04`, `0x50`, `0x2C`] → `p1 = 0x04`, `p2 = 0x50`. With `KEY_ROUTER_FIRE_EN`: `p1_fire = 1` for exactly one frame, `p2_fire = 0`.
- Held `0x16`, then report [`0x01`×6] → `p1_keycode` stays `0x16`. The next report [`0x00`] → `0x00`.
- 8-beat report whose beats 7–8 are `0x52` → `p2_keycode` unchanged (beats beyond `MAX_SLOTS` ignored). Commit still occurs on beat 8's `kc_last`.
- `Reset_n` low between beats 2 and 3 of a report [`0x1A`, `0x07`, `0x16`] → all outputs `0x00`. A following clean report [`0x16`] → `0x16`.
